// File: rtl/tree_sum_accumulator.sv
// Accumulates groups of signed tree-adder sums into one wide result.
// Halved-precision mode keeps two independent lanes with no carry between them.
module tree_sum_accumulator #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 48,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic                 halved_precision,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_ovf
);

    localparam int HI = IN_WIDTH / 2;
    localparam int HO = OUT_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [OUT_WIDTH-1:0] acc, acc_d;
    logic [LEN_WIDTH:0]   cnt, cnt_d;
    logic [LEN_WIDTH-1:0] len, len_d;
    logic                 halved, halved_d;
    logic                 ovf, ovf_d;

    logic [LEN_WIDTH-1:0] len_first;
    logic [LEN_WIDTH:0]   cnt_inc;
    logic                 cnt_hit;
    logic [OUT_WIDTH-1:0] ext_full, sum_full;
    logic [HO-1:0]        ext_lo, ext_hi;
    logic [HO-1:0]        sum_lo, sum_hi;
    logic                 ovf_full, ovf_lo, ovf_hi;

    assign ext_full = OUT_WIDTH'($signed(in_data));
    assign ext_lo   = HO'($signed(in_data[HI-1:0]));
    assign ext_hi   = HO'($signed(in_data[IN_WIDTH-1:HI]));

    assign sum_full = acc + ext_full;
    assign sum_lo   = acc[HO-1:0] + ext_lo;
    assign sum_hi   = acc[OUT_WIDTH-1:HO] + ext_hi;

    // Signed overflow: operands agree in sign, result does not.
    assign ovf_full = (acc[OUT_WIDTH-1] == ext_full[OUT_WIDTH-1])
                   && (sum_full[OUT_WIDTH-1] != acc[OUT_WIDTH-1]);
    assign ovf_lo   = (acc[HO-1] == ext_lo[HO-1])
                   && (sum_lo[HO-1] != acc[HO-1]);
    assign ovf_hi   = (acc[OUT_WIDTH-1] == ext_hi[HO-1])
                   && (sum_hi[HO-1] != acc[OUT_WIDTH-1]);

    assign len_first = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
    assign cnt_inc   = cnt + (LEN_WIDTH+1)'(1);
    assign cnt_hit   = (cnt_inc == {1'b0, len});

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign out_ovf   = ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            len    <= '0;
            halved <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_d;
            acc    <= acc_d;
            cnt    <= cnt_d;
            len    <= len_d;
            halved <= halved_d;
            ovf    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state;
        acc_d    = acc;
        cnt_d    = cnt;
        len_d    = len;
        halved_d = halved;
        ovf_d    = ovf;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    len_d    = len_first;
                    halved_d = halved_precision;
                    acc_d    = halved_precision ? {ext_hi, ext_lo}
                                                : ext_full;
                    cnt_d    = (LEN_WIDTH+1)'(1);
                    ovf_d    = 1'b0;
                    state_d  = (len_first == LEN_WIDTH'(1)) ? DONE
                                                            : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    cnt_d = cnt_inc;
                    if (halved) begin
                        acc_d = {sum_hi, sum_lo};
                        ovf_d = ovf | ovf_lo | ovf_hi;
                    end else begin
                        acc_d = sum_full;
                        ovf_d = ovf | ovf_full;
                    end
                    if (cnt_hit) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Randomized and directed checks of tree_sum_accumulator against
// an arithmetic reference model (range-checked signed sums).
module tb_tree_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_len;
    logic        hp;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_ovf;

    logic [7:0]  c_len;
    logic        c_hp;
    logic [31:0] c_data;
    logic        c_valid;
    logic        c_ready;
    logic [31:0] c_odata;
    logic        c_ovalid;
    logic        c_oready;
    logic        c_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tree_sum_accumulator #(
        .IN_WIDTH(32), .OUT_WIDTH(48), .LEN_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len),
        .halved_precision(hp), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_ovf(out_ovf)
    );

    tree_sum_accumulator #(
        .IN_WIDTH(32), .OUT_WIDTH(32), .LEN_WIDTH(8)
    ) dut32 (
        .clk(clk), .rst(rst), .cfg_len(c_len),
        .halved_precision(c_hp), .in_data(c_data),
        .in_valid(c_valid), .in_ready(c_ready),
        .out_data(c_odata), .out_valid(c_ovalid),
        .out_ready(c_oready), .out_ovf(c_ovf)
    );

    function automatic longint wrapw(longint v, int w);
        longint m, r;
        m = longint'(1) << w;
        r = v & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    function automatic bit out_of_range(longint v, int w);
        longint mx, mn;
        mx = (longint'(1) << (w - 1)) - 1;
        mn = -(longint'(1) << (w - 1));
        return (v > mx) || (v < mn);
    endfunction

    function automatic void model(input bit hpm, input logic [31:0] q[$],
                                  output logic [47:0] d, output bit o);
        longint a, l, h, x, xl, xh;
        a = 0; l = 0; h = 0; o = 1'b0;
        foreach (q[i]) begin
            x  = longint'($signed(q[i]));
            xl = longint'($signed(q[i][15:0]));
            xh = longint'($signed(q[i][31:16]));
            if (i == 0) begin
                a = x; l = xl; h = xh;
            end else if (!hpm) begin
                if (out_of_range(a + x, 48)) o = 1'b1;
                a = wrapw(a + x, 48);
            end else begin
                if (out_of_range(l + xl, 24)) o = 1'b1;
                if (out_of_range(h + xh, 24)) o = 1'b1;
                l = wrapw(l + xl, 24);
                h = wrapw(h + xh, 24);
            end
        end
        d = hpm ? {h[23:0], l[23:0]} : a[47:0];
    endfunction

    task automatic run_group(input string name, input logic [7:0] cfg,
                             input bit hpm, input logic [31:0] q[$],
                             input int gaps[$], input int stall,
                             output logic [47:0] got_d,
                             output logic got_o);
        logic [47:0] ed;
        bit eo;
        model(hpm, q, ed, eo);
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0 && i < gaps.size()) begin
                for (int g = 0; g < gaps[i]; g++) begin
                    cfg_len = 8'($urandom);
                    hp = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
            if (i == 0) begin
                cfg_len = cfg; hp = hpm;
            end else begin
                cfg_len = 8'($urandom); hp = 1'($urandom);
            end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s beat%0d: in_ready=%b out_valid=%b, need 1/0",
                         name, i, in_ready, out_valid);
            end
            in_data = q[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0; in_data = $urandom;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: out_valid=%b, need 1", name, out_valid);
        end
        checks++;
        if (out_data !== ed) begin
            errors++;
            $display("FAIL %s data: got %h, need %h", name, out_data, ed);
        end
        checks++;
        if (out_ovf !== eo) begin
            errors++;
            $display("FAIL %s ovf: got %b, need %b", name, out_ovf, eo);
        end
        got_d = out_data; got_o = out_ovf;
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== ed) begin
                errors++;
                $display("FAIL %s stall%0d: rdy=%b vld=%b data=%h, need 0/1/%h",
                         name, s, in_ready, out_valid, out_data, ed);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: vld=%b rdy=%b, need 0/1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 48'd0 || out_ovf !== 1'b0
            || c_ovalid !== 1'b0) begin
            errors++;
            $display("FAIL reset: vld=%b data=%h ovf=%b, need 0/0/0",
                     out_valid, out_data, out_ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b, need 1", in_ready);
        end
    endtask

    task automatic test_full_basic();
        logic [31:0] q[$];
        int g[$];
        logic [47:0] d;
        logic o;
        q = '{32'd36, 32'hFFFF_FFFC, 32'd0, 32'd183};
        g = '{0, 0, 0, 0};
        run_group("full4", 8'd4, 1'b0, q, g, 0, d, o);
        checks++;
        if (d !== 48'd215 || o !== 1'b0) begin
            errors++;
            $display("FAIL full4_const: got %h/%b, need %h/0", d, o, 48'd215);
        end
    endtask

    task automatic test_len0_stall();
        logic [31:0] q[$];
        int g[$];
        logic [47:0] d;
        logic o;
        q = '{32'hFFFF_FF67};
        g = '{0};
        run_group("len0", 8'd0, 1'b0, q, g, 3, d, o);
        checks++;
        if (d !== 48'hFFFF_FFFF_FF67) begin
            errors++;
            $display("FAIL len0_const: got %h, need ffffffffff67", d);
        end
    endtask

    task automatic test_halved();
        logic [31:0] q[$];
        int g[$];
        logic [47:0] d;
        logic o;
        q = '{32'h0005_FFFD, 32'hFFF6_0007};
        g = '{0, 0};
        run_group("halved", 8'd2, 1'b1, q, g, 1, d, o);
        checks++;
        if (d !== {24'hFF_FFFB, 24'h00_0004} || o !== 1'b0) begin
            errors++;
            $display("FAIL halved_const: got %h/%b, need fffffb000004/0", d, o);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] q[$];
        int g[$];
        logic [47:0] d;
        logic o;
        q = '{32'h0000_7FFF, 32'h0000_7FFF};
        g = '{0, 0};
        run_group("halved_wide", 8'd2, 1'b1, q, g, 0, d, o);
        checks++;
        if (d !== 48'h0000_0000_FFFE || o !== 1'b0) begin
            errors++;
            $display("FAIL halved_wide_const: got %h/%b, need 00000000fffe/0",
                     d, o);
        end
        c_len = 8'd2; c_hp = 1'b0;
        c_data = 32'h7FFF_FFFF; c_valid = 1'b1;
        @(posedge clk); #1;
        c_data = 32'd1;
        @(posedge clk); #1;
        c_valid = 1'b0;
        checks++;
        if (c_ovalid !== 1'b1 || c_odata !== 32'h8000_0000 || c_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf32: vld=%b data=%h ovf=%b, need 1/80000000/1",
                     c_ovalid, c_odata, c_ovf);
        end
        c_oready = 1'b1;
        @(posedge clk); #1;
        c_oready = 1'b0;
        checks++;
        if (c_ovalid !== 1'b0 || c_ready !== 1'b1) begin
            errors++;
            $display("FAIL ovf32_release: vld=%b rdy=%b, need 0/1",
                     c_ovalid, c_ready);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] q[$];
        int g[$];
        logic [47:0] d;
        logic o;
        q = '{32'd1, 32'd2, 32'd3};
        g = '{0, 1, 2};
        run_group("gaps", 8'd3, 1'b0, q, g, 0, d, o);
        checks++;
        if (d !== 48'd6) begin
            errors++;
            $display("FAIL gaps_const: got %h, need 6", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q[$];
        int g[$];
        logic [47:0] d;
        logic o;
        bit seen;
        cfg_len = 8'd4; hp = 1'b0;
        in_valid = 1'b1; in_data = 32'd100;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid: out_valid rose, need 0");
        end
        q = '{32'd10, 32'd20};
        g = '{0, 0};
        run_group("after_reset", 8'd2, 1'b0, q, g, 0, d, o);
        checks++;
        if (d !== 48'd30) begin
            errors++;
            $display("FAIL after_reset_const: got %h, need 30", d);
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        int g[$];
        logic [47:0] d;
        logic o;
        int n;
        bit m;
        logic [7:0] cfg;
        for (int t = 0; t < 40; t++) begin
            q = {};
            g = {};
            n = int'($urandom_range(1, 6));
            m = 1'($urandom);
            cfg = 8'(n);
            if (n == 1 && $urandom_range(0, 1) == 1) cfg = 8'd0;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0)
                    q.push_back($urandom_range(0, 1) == 1 ? 32'h7FFF_7FFF
                                                          : 32'h8000_8000);
                else
                    q.push_back($urandom);
                g.push_back(int'($urandom_range(0, 2)));
            end
            run_group($sformatf("rand%0d", t), cfg, m, q, g,
                      int'($urandom_range(0, 2)), d, o);
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_len = 8'd1; hp = 1'b0; in_data = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        c_len = 8'd1; c_hp = 1'b0; c_data = '0;
        c_valid = 1'b0; c_oready = 1'b0;
        test_reset();
        test_full_basic();
        test_len0_stall();
        test_halved();
        test_overflow();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
